key_en_ctrl: RTL

KEY_EN_CTRL -- requirements
Module: key_en_ctrl

---
 rtl/key_en_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/key_en_ctrl.sv
// Debounced push-button controller: synchronizes a raw key, qualifies presses
// over a DB_CYCLES window, strobes key_pulse once per press and toggles en.
module key_en_ctrl #(
  parameter int   DB_CYCLES  = 1000000,
  parameter int   CNT_WIDTH  = $clog2(DB_CYCLES + 1),
  parameter logic KEY_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  output logic       en,
  output logic       key_pulse,
  output logic [1:0] key_state
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DB_CYCLES - 1);

  logic                 sync1_q, sync2_q;
  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 en_q, en_d;
  logic                 pulse_q, pulse_d;
  logic                 pressed;

  assign pressed = (sync2_q == KEY_ACTIVE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= ~KEY_ACTIVE;
      sync2_q <= ~KEY_ACTIVE;
      state_q <= IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d = PRESS_DB;
          cnt_d   = '0;
        end
      end
      PRESS_DB: begin
        if (!pressed) begin
          // any release glitch throws away accumulated press time
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          pulse_d = 1'b1;
          en_d    = ~en_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!pressed) begin
          state_d = RELEASE_DB;
          cnt_d   = '0;
        end
      end
      RELEASE_DB: begin
        if (pressed) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign en        = en_q;
  assign key_pulse = pulse_q;
  assign key_state = state_q;

endmodule
